// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/2 K=3 (7,5 octal) convolutional encoder with a single-entry output register.
// Optional tail flushing is enabled by defining CONV_ENC_TAIL_EN; without it, frames end unterminated.
module conv_encoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [1:0]       sym_out,
    output logic             sym_valid,
    input  logic             sym_ready,
    output logic             sym_last,
    output logic [1:0]       enc_state,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             cnt_ovf
);

    typedef enum logic [1:0] {IDLE, DATA, TAIL1, TAIL2} state_t;

    state_t     state, state_nx;
    logic       live;
    logic       free;
    logic       accept;
    logic       tail_go;
    logic       u;
    logic       last_nx;
    logic [1:0] enc_nx;

    // live holds in_ready low for the first cycle after reset releases
    assign free     = !sym_valid || sym_ready;
    assign in_ready = live && (state == IDLE || state == DATA) && free;
    assign accept   = in_valid && in_ready;
`ifdef CONV_ENC_TAIL_EN
    assign tail_go  = free && (state == TAIL1 || state == TAIL2);
`else
    assign tail_go  = 1'b0;
`endif
    // tail symbols are encoded with a forced zero input
    assign u = accept && in_bit;

    // next FSM state, next trellis state and sym_last for the symbol being loaded
    always_comb begin
        state_nx = state;
        enc_nx   = enc_state;
        last_nx  = 1'b0;
        if (accept) begin
            enc_nx = {in_bit, enc_state[1]};
`ifdef CONV_ENC_TAIL_EN
            state_nx = in_last ? TAIL1 : DATA;
`else
            state_nx = in_last ? IDLE : DATA;
            if (in_last) begin
                enc_nx  = 2'b00;
                last_nx = 1'b1;
            end
`endif
        end else if (tail_go) begin
            enc_nx   = {1'b0, enc_state[1]};
            state_nx = (state == TAIL1) ? TAIL2 : IDLE;
            last_nx  = (state == TAIL2);
        end
    end

    // FSM, trellis state and output register; a load wins over a drain on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live      <= 1'b0;
            state     <= IDLE;
            enc_state <= 2'b00;
            sym_out   <= 2'b00;
            sym_valid <= 1'b0;
            sym_last  <= 1'b0;
        end else begin
            live      <= 1'b1;
            state     <= state_nx;
            enc_state <= enc_nx;
            if (accept || tail_go) begin
                sym_out   <= {u ^ enc_state[1] ^ enc_state[0], u ^ enc_state[0]};
                sym_valid <= 1'b1;
                sym_last  <= last_nx;
            end else if (sym_ready) begin
                sym_valid <= 1'b0;
                sym_last  <= 1'b0;
            end
        end
    end

    // per-frame info-bit counter; restarts at 1 on the first bit of a frame and saturates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            cnt_ovf <= 1'b0;
        end else if (accept) begin
            if (state == IDLE) begin
                bit_cnt <= CNT_W'(1);
                cnt_ovf <= 1'b0;
            end else if (&bit_cnt) begin
                cnt_ovf <= 1'b1;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder: random and directed frames against a frame-level reference encoder.
module tb_conv_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_bit = 1'b0, in_valid = 1'b0, in_last = 1'b0, sym_ready = 1'b0;
    logic       in_ready, sym_valid, sym_last;
    logic [1:0] sym_out, enc_state;
    logic [7:0] bit_cnt;
    logic       cnt_ovf;
    logic       in_ready2, sym_valid2, sym_last2, cnt_ovf2;
    logic [1:0] sym_out2, enc_state2, bit_cnt2;

    conv_encoder u_dut (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .sym_out(sym_out), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .sym_last(sym_last), .enc_state(enc_state), .bit_cnt(bit_cnt), .cnt_ovf(cnt_ovf)
    );

    conv_encoder #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready2), .sym_out(sym_out2), .sym_valid(sym_valid2), .sym_ready(sym_ready),
        .sym_last(sym_last2), .enc_state(enc_state2), .bit_cnt(bit_cnt2), .cnt_ovf(cnt_ovf2)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] sym; logic last; } ent_t;
    ent_t       q[$];
    logic       fb[$];
    logic [1:0] cap[$];
    int         n_chk = 0, n_fail = 0;
    logic       acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic bt(input int i);
        return (i >= 0 && i < fb.size()) ? fb[i] : 1'b0;
    endfunction

    // symbol for frame position i from the 7/5 generators over the bit history
    function automatic logic [1:0] enc_sym(input int i);
        return {bt(i) ^ bt(i-1) ^ bt(i-2), bt(i) ^ bt(i-2)};
    endfunction

    task automatic model_accept(input logic b, input logic l);
        int n;
        fb.push_back(b);
        n = fb.size();
        chk("bit_cnt", 32'(bit_cnt), n > 255 ? 255 : n);
        chk("cnt_ovf", 32'(cnt_ovf), 32'(n > 255));
        chk("bit_cnt_sat", 32'(bit_cnt2), n > 3 ? 3 : n);
        chk("cnt_ovf_sat", 32'(cnt_ovf2), 32'(n > 3));
`ifdef CONV_ENC_TAIL_EN
        chk("enc_state", 32'(enc_state), 32'({b, bt(n-2)}));
        q.push_back('{enc_sym(n-1), 1'b0});
        if (l) begin
            q.push_back('{enc_sym(n), 1'b0});
            q.push_back('{enc_sym(n+1), 1'b1});
            fb.delete();
        end
`else
        chk("enc_state", 32'(enc_state), l ? 32'd0 : 32'({b, bt(n-2)}));
        q.push_back('{enc_sym(n-1), l});
        if (l) fb.delete();
`endif
    endtask

    // one clock: drive at negedge, check outputs, then apply the edge's effects to the model
    task automatic cycle(input logic v, input logic b, input logic l, input logic r);
        logic hs;
        in_valid = v; in_bit = b; in_last = l; sym_ready = r;
        #1;
        chk("in_ready", 32'(in_ready), q.size() == 0 ? 32'd1 : q.size() == 1 ? 32'(r) : 32'd0);
        chk("sym_valid", 32'(sym_valid), 32'(q.size() > 0));
        if (sym_valid && q.size() > 0) begin
            chk("sym_out", 32'(sym_out), 32'(q[0].sym));
            chk("sym_last", 32'(sym_last), 32'(q[0].last));
        end
        acc = v && in_ready;
        hs  = sym_valid && r;
        @(posedge clk);
        @(negedge clk);
        if (hs && q.size() > 0) begin
            cap.push_back(q[0].sym);
            void'(q.pop_front());
        end
        if (acc) model_accept(b, l);
    endtask

    task automatic send_frame(input logic [7:0] bits, input int len, input int vp, input int rp);
        int idx = 0;
        for (int k = 0; k < 300 && idx < len; k++) begin
            cycle($urandom_range(99) < vp, bits[idx], idx == len - 1, $urandom_range(99) < rp);
            if (acc) idx++;
        end
        chk("frame_sent", idx, len);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && q.size() > 0; k++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("drain", q.size(), 0);
    endtask

    task automatic check_reset();
        chk("rst_sym_valid", 32'(sym_valid), 0);
        chk("rst_sym_out", 32'(sym_out), 0);
        chk("rst_sym_last", 32'(sym_last), 0);
        chk("rst_enc_state", 32'(enc_state), 0);
        chk("rst_bit_cnt", 32'(bit_cnt), 0);
        chk("rst_cnt_ovf", 32'(cnt_ovf), 0);
        chk("rst_bit_cnt_sat", 32'(bit_cnt2), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
    endtask

    task automatic release_reset();
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 0);
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] exp_syms [6];
        int         elen;
`ifdef CONV_ENC_TAIL_EN
        exp_syms = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        elen = 6;
`else
        exp_syms = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
        elen = 4;
`endif
        repeat (2) @(negedge clk);
        #1;
        check_reset();
        @(negedge clk);
        release_reset();

        // reference frame 1,0,1,1 with the consumer always ready
        cap.delete();
        send_frame(8'b0000_1101, 4, 100, 100);
        drain();
        chk("ref_len", cap.size(), elen);
        for (int i = 0; i < elen && i < cap.size(); i++) chk("ref_sym", 32'(cap[i]), 32'(exp_syms[i]));
        chk("ref_enc_end", 32'(enc_state), 0);
        chk("ref_bit_cnt", 32'(bit_cnt), 4);

        // consumer stalls for 3 cycles after the first symbol
        cap.delete();
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'b0000_0110, 3, 100, 100);
        drain();
        chk("stall_len", cap.size(), elen);
        for (int i = 0; i < elen && i < cap.size(); i++) chk("stall_sym", 32'(cap[i]), 32'(exp_syms[i]));

        // in_valid held high across the tail into the next frame
        send_frame(8'b0000_1101, 4, 100, 100);
        send_frame(8'b0000_0110, 3, 100, 100);
        drain();

        // counter saturation on the narrow instance, then clear on the next frame
        send_frame(8'b0001_1111, 5, 100, 100);
        send_frame(8'b0000_0001, 2, 100, 100);
        drain();

        // reset right after the last bit (TAIL1 when tails are enabled)
        send_frame(8'b0000_1101, 4, 100, 100);
        sym_ready = 1'b0;
        rst = 1'b1;
        #1;
        check_reset();
        q.delete();
        fb.delete();
        @(negedge clk);
        release_reset();
        send_frame(8'b0000_0001, 2, 100, 100);
        drain();

        // random frames with random valid/ready pressure
        for (int f = 0; f < 30; f++) send_frame(8'($urandom), $urandom_range(1, 8), $urandom_range(40, 100), $urandom_range(30, 100));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 Parameter CNT_W, default 8, width of the per-frame info-bit counter.
REQ-002 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-high.
REQ-004 Port in_bit  input  1  information bit u.
REQ-005 Port in_valid  input  1  in_bit/in_last are valid.
REQ-006 Port in_last  input  1  marks the final info bit of a frame.
REQ-007 Port in_ready  output  1  the encoder accepts an input this cycle.
REQ-008 Port sym_out  output  2  coded symbol {c0,c1}; c0 on bit 1, c1 on bit 0.
REQ-009 Port sym_valid  output  1  sym_out holds a symbol.
REQ-010 Port sym_ready  input  1  the downstream consumer takes the symbol.
REQ-011 Port sym_last  output  1  the final symbol of the frame.
REQ-012 Port enc_state  output  2  trellis state {a,b}: a = newest shifted bit, b = previous bit.
REQ-013 Port bit_cnt  output  CNT_W  number of info bits accepted in the current frame.
REQ-014 Port cnt_ovf  output  1  sticky flag: bit_cnt saturated in this frame.

Function
REQ-015 Code definition: rate 1/2, K=3, generators 7/5 octal; c0 = u^a^b, c1 = u^b; next state = {u,a}.
REQ-016 Symbol map, matching the decoder path IDs:
- 00 -> 00 or 11 (u=0/1)
- 01 -> 11 or 00
- 10 -> 10 or 01
- 11 -> 01 or 10
REQ-017 FSM states: IDLE, DATA, TAIL1, TAIL2.
- IDLE -> DATA on the first accepted bit.
- DATA -> TAIL1 on an accepted bit with in_last=1.
- TAIL1 -> TAIL2 when the output register is free.
- TAIL2 -> IDLE when the output register is free.
REQ-018 in_ready = (state is IDLE or DATA) and (sym_valid==0 or sym_ready==1).
REQ-019 An accept (in_valid & in_ready) loads sym_out, sym_valid=1 and the next state on the same edge; latency is 1 cycle.
REQ-020 Tail symbols: in TAIL1 and TAIL2 the encoder forces u=0, emits one symbol per free output slot, and asserts sym_last with the TAIL2 symbol.
REQ-021 After TAIL2, enc_state is 00 by construction; each frame starts in state 00.
REQ-022 While sym_valid=1 and sym_ready=0, sym_out, sym_last and sym_valid hold stable.
REQ-023 sym_valid clears on a sym_ready cycle if no new symbol loads on the same edge.
REQ-024 Simultaneous sym_ready and accept: the new symbol replaces the old one with no bubble.
REQ-025 bit_cnt increments per accepted bit and clears on the first accepted bit of a new frame (it loads 1).
REQ-026 bit_cnt saturates at 2^CNT_W-1; cnt_ovf sets on an attempted increment past saturation and clears at the next frame start.
REQ-027 in_valid while in TAIL1 or TAIL2 is ignored, because in_ready=0.

Reset
REQ-028 On rst=1, immediately and independent of clk: state=IDLE, enc_state=00, sym_out=00, sym_valid=0, sym_last=0, bit_cnt=0, cnt_ovf=0, in_ready=0.
REQ-029 After rst deasserts, in_ready=1 from the next cycle.
REQ-030 Reset in mid-frame or mid-tail discards the pending symbol and any remaining tail.

Configuration
REQ-031 Macro CONV_ENC_TAIL_EN.
- Defined: tail flushing per REQ-017/REQ-020 applies.
- Undefined: no TAIL states; sym_last asserts on the symbol of the in_last bit, and enc_state is forced to 00 on the same edge. The frame is unterminated.

Verification
REQ-032 Tail enabled, frame bits 1,0,1,1 (last), sym_ready=1 -> sym_out 11,10,00,01,01,11 on consecutive cycles; sym_last only on the 6th symbol; enc_state ends 00; bit_cnt=4.
REQ-033 Same frame, tail disabled -> symbols 11,10,00,01; sym_last on the 4th; enc_state=00 afterwards.
REQ-034 sym_ready low for 3 cycles after the first symbol -> sym_out holds 11, in_ready=0, nothing is lost; the sequence resumes unchanged.
REQ-035 in_valid held high through the tail -> in_ready=0 during TAIL1/TAIL2; the next frame's first bit is accepted the cycle after TAIL2 drains.
REQ-036 rst pulse during TAIL1 -> all outputs take their REQ-028 values; the next frame bit 1 yields 11 with enc_state 10.
REQ-037 CNT_W=2, 5-bit frame -> bit_cnt saturates at 3 and cnt_ovf=1; both clear on the next frame's first bit (bit_cnt=1).
